// File: rtl/branch_pred_ctrl.sv
// Branch predictor controller: direct-mapped tagged table of targets and
// saturating counters. Registered one-cycle lookup for fetch, table update
// and registered redirect on mispredict from EX-stage resolution.
// Optional macro BP_STATS_EN adds saturating branch/mispredict counters.
module branch_pred_ctrl #(
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        f_valid,
    input  logic [31:0] f_pc,
    output logic        p_valid,
    output logic        p_taken,
    output logic [31:0] p_target,
    input  logic        r_valid,
    input  logic [31:0] r_pc,
    input  logic        r_is_branch,
    input  logic        r_taken,
    input  logic [31:0] r_target,
    input  logic        r_pred_taken,
    input  logic [31:0] r_pred_target,
    output logic        redirect,
    output logic [31:0] redirect_pc
`ifdef BP_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
`endif
);

    localparam int IW = $clog2(ENTRIES);
    localparam int TW = 30 - IW;
    localparam logic [CTR_W-1:0] CTR_MAX     = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] CTR_WEAK_NT = {1'b0, {(CTR_W-1){1'b1}}};
    localparam logic [CTR_W-1:0] CTR_WEAK_T  = {1'b1, {(CTR_W-1){1'b0}}};

    logic          tbl_valid  [ENTRIES];
    logic [TW-1:0] tbl_tag    [ENTRIES];
    logic [31:0]   tbl_target [ENTRIES];
    logic [CTR_W-1:0] tbl_ctr [ENTRIES];

    // Saturating step of a prediction counter toward taken or not-taken.
    function automatic logic [CTR_W-1:0] ctr_step(input logic [CTR_W-1:0] c, input logic up);
        if (up) return (c == CTR_MAX) ? c : c + 1'b1;
        else    return (c == '0) ? c : c - 1'b1;
    endfunction

    // Saturating 32-bit event counter increment.
    function automatic logic [31:0] sat_inc32(input logic [31:0] c, input logic en);
        return (en && c != 32'hFFFF_FFFF) ? c + 32'd1 : c;
    endfunction

    logic [IW-1:0] f_idx;
    logic [TW-1:0] f_tag;
    logic          f_hit;
    logic          f_taken;
    logic [IW-1:0] r_idx;
    logic [TW-1:0] r_tag;
    logic          r_hit;
    logic          act_taken;
    logic          mispredict;
    logic [31:0]   fix_pc;

    assign f_idx   = f_pc[IW+1:2];
    assign f_tag   = f_pc[31:IW+2];
    assign f_hit   = tbl_valid[f_idx] && (tbl_tag[f_idx] == f_tag);
    assign f_taken = f_hit && tbl_ctr[f_idx][CTR_W-1];

    assign r_idx = r_pc[IW+1:2];
    assign r_tag = r_pc[31:IW+2];
    assign r_hit = tbl_valid[r_idx] && (tbl_tag[r_idx] == r_tag);

    // A non-branch is treated as actually not-taken, so a taken prediction on it mispredicts.
    assign act_taken  = r_is_branch && r_taken;
    assign mispredict = r_valid && ((act_taken != r_pred_taken) ||
                                    (act_taken && r_pred_taken && (r_target != r_pred_target)));
    assign fix_pc     = act_taken ? r_target : r_pc + 32'd4;

    // Lookup stage: register prediction from pre-update table contents.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p_valid  <= 1'b0;
            p_taken  <= 1'b0;
            p_target <= 32'd0;
        end else begin
            p_valid  <= f_valid;
            p_taken  <= f_valid && f_taken;
            p_target <= !f_valid ? 32'd0 : (f_taken ? tbl_target[f_idx] : f_pc + 32'd4);
        end
    end

    // Redirect: one-cycle pulse per mispredict; the pc holds its last value otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            redirect    <= 1'b0;
            redirect_pc <= 32'd0;
        end else begin
            redirect <= mispredict;
            if (mispredict) redirect_pc <= fix_pc;
        end
    end

    // Table control state: valid bits and counters (allocate, train, invalidate aliases).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl_valid[i] <= 1'b0;
                tbl_ctr[i]   <= CTR_WEAK_NT;
            end
        end else if (r_valid) begin
            if (r_is_branch) begin
                if (r_hit) begin
                    tbl_ctr[r_idx] <= ctr_step(tbl_ctr[r_idx], r_taken);
                end else if (r_taken) begin
                    tbl_valid[r_idx] <= 1'b1;
                    tbl_ctr[r_idx]   <= CTR_WEAK_T;
                end
            end else if (r_hit) begin
                tbl_valid[r_idx] <= 1'b0;
            end
        end
    end

    // Table data: tag and target written by taken branches (hit retrains target, miss allocates).
    always_ff @(posedge clk) begin
        if (r_valid && r_is_branch && r_taken) begin
            tbl_tag[r_idx]    <= r_tag;
            tbl_target[r_idx] <= r_target;
        end
    end

`ifdef BP_STATS_EN
    // Statistics: resolved branches and mispredicts, saturating.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_branches    <= 32'd0;
            stat_mispredicts <= 32'd0;
        end else begin
            stat_branches    <= sat_inc32(stat_branches, r_valid && r_is_branch);
            stat_mispredicts <= sat_inc32(stat_mispredicts, mispredict);
        end
    end
`else
    // Statistics hardware absent in this build; keep the helper referenced.
    logic [31:0] unused_stat;
    assign unused_stat = sat_inc32(32'd0, 1'b0);
`endif

endmodule

// File: tb/tb_branch_pred_ctrl.sv
// Directed, table-driven bench for branch_pred_ctrl (ENTRIES=16, CTR_W=2).
module tb_branch_pred_ctrl;

    logic        clk;
    logic        reset_n;
    logic        f_valid;
    logic [31:0] f_pc;
    logic        p_valid;
    logic        p_taken;
    logic [31:0] p_target;
    logic        r_valid;
    logic [31:0] r_pc;
    logic        r_is_branch;
    logic        r_taken;
    logic [31:0] r_target;
    logic        r_pred_taken;
    logic [31:0] r_pred_target;
    logic        redirect;
    logic [31:0] redirect_pc;
`ifdef BP_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    int total = 0;
    int bad   = 0;

    branch_pred_ctrl #(.ENTRIES(16), .CTR_W(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .f_valid(f_valid), .f_pc(f_pc),
        .p_valid(p_valid), .p_taken(p_taken), .p_target(p_target),
        .r_valid(r_valid), .r_pc(r_pc), .r_is_branch(r_is_branch), .r_taken(r_taken),
        .r_target(r_target), .r_pred_taken(r_pred_taken), .r_pred_target(r_pred_target),
        .redirect(redirect), .redirect_pc(redirect_pc)
`ifdef BP_STATS_EN
        , .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        fv;
        logic [31:0] fpc;
        logic        rv;
        logic [31:0] rpc;
        logic        br;
        logic        tk;
        logic [31:0] tgt;
        logic        pt;
        logic [31:0] ptgt;
        logic        e_pv;
        logic        e_ptk;
        logic [31:0] e_ptgt;
        logic        e_rd;
        logic [31:0] e_rdpc;
    } vec_t;

    vec_t vecs [22];

    function automatic vec_t mk(input logic fv, input logic [31:0] fpc,
                                input logic rv, input logic [31:0] rpc, input logic br,
                                input logic tk, input logic [31:0] tgt, input logic pt,
                                input logic [31:0] ptgt, input logic e_pv, input logic e_ptk,
                                input logic [31:0] e_ptgt, input logic e_rd, input logic [31:0] e_rdpc);
        vec_t v;
        v.fv = fv; v.fpc = fpc; v.rv = rv; v.rpc = rpc; v.br = br; v.tk = tk; v.tgt = tgt;
        v.pt = pt; v.ptgt = ptgt; v.e_pv = e_pv; v.e_ptk = e_ptk; v.e_ptgt = e_ptgt;
        v.e_rd = e_rd; v.e_rdpc = e_rdpc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic fv, input logic [31:0] fpc, input logic rv,
                         input logic [31:0] rpc, input logic br, input logic tk,
                         input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt);
        f_valid = fv; f_pc = fpc; r_valid = rv; r_pc = rpc; r_is_branch = br;
        r_taken = tk; r_target = tgt; r_pred_taken = pt; r_pred_target = ptgt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // fv fpc | rv rpc br tk tgt pt ptgt | pv ptk ptgt | rd rdpc
        vecs[0]  = mk(1, 32'h100, 0, 0,       0, 0, 0,       0, 0,       1, 0, 32'h104, 0, 0);
        vecs[1]  = mk(0, 0,       1, 32'h100, 1, 1, 32'h200, 0, 0,       0, 0, 0,       1, 32'h200);
        vecs[2]  = mk(1, 32'h100, 0, 0,       0, 0, 0,       0, 0,       1, 1, 32'h200, 0, 32'h200);
        vecs[3]  = mk(1, 32'h100, 1, 32'h100, 1, 1, 32'h200, 1, 32'h200, 1, 1, 32'h200, 0, 32'h200);
        vecs[4]  = mk(1, 32'h100, 1, 32'h100, 1, 1, 32'h300, 1, 32'h200, 1, 1, 32'h200, 1, 32'h300);
        vecs[5]  = mk(1, 32'h100, 0, 0,       0, 0, 0,       0, 0,       1, 1, 32'h300, 0, 32'h300);
        vecs[6]  = mk(0, 0,       1, 32'h100, 1, 0, 0,       1, 32'h300, 0, 0, 0,       1, 32'h104);
        vecs[7]  = mk(1, 32'h100, 1, 32'h100, 1, 0, 0,       1, 32'h300, 1, 1, 32'h300, 1, 32'h104);
        vecs[8]  = mk(1, 32'h100, 0, 0,       0, 0, 0,       0, 0,       1, 0, 32'h104, 0, 32'h104);
        vecs[9]  = mk(0, 0,       1, 32'h100, 1, 0, 0,       0, 0,       0, 0, 0,       0, 32'h104);
        vecs[10] = mk(0, 0,       1, 32'h100, 1, 0, 0,       0, 0,       0, 0, 0,       0, 32'h104);
        vecs[11] = mk(0, 0,       1, 32'h100, 1, 1, 32'h200, 0, 0,       0, 0, 0,       1, 32'h200);
        vecs[12] = mk(1, 32'h100, 1, 32'h504, 1, 1, 32'h600, 0, 0,       1, 0, 32'h104, 1, 32'h600);
        vecs[13] = mk(1, 32'h504, 1, 32'h140, 0, 0, 0,       1, 32'h999, 1, 1, 32'h600, 1, 32'h144);
        vecs[14] = mk(1, 32'h140, 1, 32'h100, 1, 1, 32'h200, 1, 32'h200, 1, 0, 32'h144, 0, 32'h144);
        vecs[15] = mk(1, 32'h100, 1, 32'h100, 0, 0, 0,       0, 0,       1, 1, 32'h200, 0, 32'h144);
        vecs[16] = mk(1, 32'h100, 0, 0,       0, 0, 0,       0, 0,       1, 0, 32'h104, 0, 32'h144);
        vecs[17] = mk(0, 0,       0, 0,       0, 0, 0,       0, 0,       0, 0, 0,       0, 32'h144);
        vecs[18] = mk(0, 0,       1, 32'h100, 1, 0, 0,       0, 0,       0, 0, 0,       0, 32'h144);
        vecs[19] = mk(1, 32'h100, 0, 0,       0, 0, 0,       0, 0,       1, 0, 32'h104, 0, 32'h144);
        vecs[20] = mk(1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0, 0, 0, 1, 32'h5, 1, 0, 32'h0, 1, 32'h0);
        vecs[21] = mk(0, 0,       0, 0,       0, 0, 0,       0, 0,       0, 0, 0,       0, 32'h0);

        reset_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset p_valid", {31'd0, p_valid}, 32'd0);
        chk("reset p_taken", {31'd0, p_taken}, 32'd0);
        chk("reset p_target", p_target, 32'd0);
        chk("reset redirect", {31'd0, redirect}, 32'd0);
        chk("reset redirect_pc", redirect_pc, 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 22; i++) begin
            drive(vecs[i].fv, vecs[i].fpc, vecs[i].rv, vecs[i].rpc, vecs[i].br, vecs[i].tk,
                  vecs[i].tgt, vecs[i].pt, vecs[i].ptgt);
            tick();
            chk($sformatf("v%0d p_valid", i), {31'd0, p_valid}, {31'd0, vecs[i].e_pv});
            chk($sformatf("v%0d p_taken", i), {31'd0, p_taken}, {31'd0, vecs[i].e_ptk});
            chk($sformatf("v%0d p_target", i), p_target, vecs[i].e_ptgt);
            chk($sformatf("v%0d redirect", i), {31'd0, redirect}, {31'd0, vecs[i].e_rd});
            chk($sformatf("v%0d redirect_pc", i), redirect_pc, vecs[i].e_rdpc);
        end

        // Reset arriving while an update is presented: outputs clear at once, update lost.
        drive(1, 32'h100, 1, 32'h100, 1, 1, 32'h200, 0, 0);
        tick();
        chk("pre-reset p_valid", {31'd0, p_valid}, 32'd1);
        chk("pre-reset redirect", {31'd0, redirect}, 32'd1);
        drive(1, 32'h204, 1, 32'h204, 1, 1, 32'h700, 0, 0);
        #1 reset_n = 1'b0;
        #1;
        chk("async reset p_valid", {31'd0, p_valid}, 32'd0);
        chk("async reset p_target", p_target, 32'd0);
        chk("async reset redirect", {31'd0, redirect}, 32'd0);
        chk("async reset redirect_pc", redirect_pc, 32'd0);
        tick();
        reset_n = 1'b1;
        drive(1, 32'h100, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("post-reset 0x100 p_taken", {31'd0, p_taken}, 32'd0);
        chk("post-reset 0x100 p_target", p_target, 32'h104);
        drive(1, 32'h204, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("post-reset 0x204 p_taken", {31'd0, p_taken}, 32'd0);
        chk("post-reset 0x204 p_target", p_target, 32'h208);
        chk("post-reset redirect", {31'd0, redirect}, 32'd0);

`ifdef BP_STATS_EN
        chk("stat_branches after reset", stat_branches, 32'd0);
        chk("stat_mispredicts after reset", stat_mispredicts, 32'd0);
        drive(0, 0, 1, 32'h800, 1, 1, 32'h900, 0, 0);        tick();
        drive(0, 0, 1, 32'h800, 1, 1, 32'h900, 1, 32'h900);  tick();
        drive(0, 0, 1, 32'h800, 1, 0, 0,       0, 0);        tick();
        drive(0, 0, 1, 32'h808, 1, 1, 32'hA00, 1, 32'h999);  tick();
        drive(0, 0, 1, 32'h80C, 1, 0, 0,       0, 0);        tick();
        drive(0, 0, 1, 32'h810, 0, 0, 0,       0, 0);        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("stat_branches", stat_branches, 32'd5);
        chk("stat_mispredicts", stat_mispredicts, 32'd2);
        #2 reset_n = 1'b0;
        #2 reset_n = 1'b1;
        chk("stat_branches cleared", stat_branches, 32'd0);
        chk("stat_mispredicts cleared", stat_mispredicts, 32'd0);
`endif

        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
